turn_request_scheduler: RTL

Arbitrates the driver's turn and hazard requests for the tail-light sequencer and sequences mode changes so a blink pattern is never cut mid-sequence. It sits between the board inputs (KEY/SW) and the tail-light state machine, in the divided clock domain. It drives that machine's left/right/hazard inputs and exports a 3-bit state code for the seven-segment decoders.

---
 rtl/turn_request_scheduler_pkg.sv | 40 ++++
 rtl/turn_request_scheduler_key_sync_edge.sv | 36 +++
 rtl/turn_request_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/turn_request_scheduler_pkg.sv
// Shared tail-light definitions: scheduler state codes (also used by the
// seven-segment decoders), pending-request bit positions and small helpers.
package turn_request_scheduler_pkg;

    // State codes double as the 3-bit value shown on the seven-segment display.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_HAZARD = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Bit positions inside the 2-bit pending vector {right, left}.
    localparam int PEND_LEFT_BIT  = 0;
    localparam int PEND_RIGHT_BIT = 1;

    localparam logic [1:0] PEND_NONE  = 2'b00;
    localparam logic [1:0] PEND_LEFT  = 2'b01;
    localparam logic [1:0] PEND_RIGHT = 2'b10;

    // Requests driven into the tail-light sequencer.
    typedef struct packed {
        logic left;
        logic right;
        logic hazard;
    } enables_t;

    // State to enter once the current pattern may be abandoned.
    function automatic state_t pending_target(input logic [1:0] pend);
        if (pend[PEND_RIGHT_BIT]) begin
            return ST_RIGHT;
        end
        if (pend[PEND_LEFT_BIT]) begin
            return ST_LEFT;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/turn_request_scheduler_key_sync_edge.sv
// Two-flop synchronizer for a raw board input, plus a registered one-cycle
// pulse on every synchronized falling edge.
module key_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronize the raw input and register a pulse when it goes 1 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= RESET_VAL;
            sync   <= RESET_VAL;
            sync_d <= RESET_VAL;
            fall   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its neighbour, which is what builds the chain.
            meta   <= raw;
            sync   <= meta;
            sync_d <= sync;
            fall   <= sync_d & ~sync;
        end
    end

    assign level = sync;

endmodule

// File: rtl/turn_request_scheduler.sv
// Turn/hazard request scheduler for the tail-light sequencer. Conditions the
// board inputs, arbitrates requests and lets a running blink pattern finish
// (DRAIN) before switching mode; hazard preempts immediately.
module turn_request_scheduler
    import turn_request_scheduler_pkg::*;
#(
    parameter int AUTO_CANCEL_TICKS = 64,
    parameter int CNT_W             = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       seq_done,
    input  logic       left_key_n,
    input  logic       right_key_n,
    input  logic       hazard_sw,
    output logic       left_en,
    output logic       right_en,
    output logic       hazard_en,
    output logic [1:0] pending,
    output logic [2:0] state_code
);

    localparam logic [CNT_W-1:0] CANCEL_LIMIT = CNT_W'(AUTO_CANCEL_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic press_l;
    logic press_r;
    logic hazard_level;

    state_t           state;
    state_t           state_next;
    logic [1:0]       pending_next;
    logic [1:0]       drain_pend;
    logic [CNT_W-1:0] cnt;
    logic             in_turn;
    logic             expired;
    logic             turn_entry;
    enables_t         en;
    enables_t         en_next;

    // Keys are idle-high, so their synchronizers reset to 1; a press is the
    // falling edge. The hazard switch only needs its synchronized level.
    key_sync_edge #(.RESET_VAL(1'b1)) u_left_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (left_key_n),
        .level (),
        .fall  (press_l)
    );

    key_sync_edge #(.RESET_VAL(1'b1)) u_right_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (right_key_n),
        .level (),
        .fall  (press_r)
    );

    key_sync_edge #(.RESET_VAL(1'b0)) u_hazard_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (hazard_sw),
        .level (hazard_level),
        .fall  ()
    );

    assign in_turn    = (state == ST_LEFT) || (state == ST_RIGHT);
    assign expired    = in_turn && (cnt >= CANCEL_LIMIT);
    assign turn_entry = ((state_next == ST_LEFT) || (state_next == ST_RIGHT))
                        && (state_next != state);

    // State register with the registered pending request and enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            pending <= PEND_NONE;
            en      <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            en      <= en_next;
        end
    end

    // Auto-cancel counter: cleared on entering a turn, saturating tick count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (turn_entry) begin
            cnt <= '0;
        end else if (in_turn && tick && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state and pending-request arbitration.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned and infer a latch.
        state_next   = state;
        pending_next = pending;
        drain_pend   = pending;

        unique case (state)
            ST_IDLE: begin
                if (press_l) begin
                    state_next = ST_LEFT;
                    if (press_r) begin
                        pending_next = PEND_RIGHT;
                    end
                end else if (press_r) begin
                    state_next = ST_RIGHT;
                end
            end

            ST_LEFT: begin
                // A press outranks the auto-cancel expiry.
                if (press_r) begin
                    state_next   = ST_DRAIN;
                    pending_next = PEND_RIGHT;
                end else if (press_l || expired) begin
                    state_next   = ST_DRAIN;
                    pending_next = PEND_NONE;
                end
            end

            ST_RIGHT: begin
                if (press_l) begin
                    state_next   = ST_DRAIN;
                    pending_next = PEND_LEFT;
                end else if (press_r || expired) begin
                    state_next   = ST_DRAIN;
                    pending_next = PEND_NONE;
                end
            end

            ST_DRAIN: begin
                // The held enable tells which direction is still blinking;
                // pressing that direction again withdraws the request.
                if (press_l) begin
                    drain_pend = en.left ? PEND_NONE : PEND_LEFT;
                end
                if (press_r) begin
                    drain_pend = en.right ? PEND_NONE : PEND_RIGHT;
                end
                pending_next = drain_pend;
                if (seq_done) begin
                    state_next   = pending_target(drain_pend);
                    pending_next = PEND_NONE;
                end
            end

            ST_HAZARD: begin
                if (press_l) begin
                    pending_next = PEND_LEFT;
                end
                if (press_r) begin
                    pending_next = PEND_RIGHT;
                end
                if (!hazard_level) begin
                    state_next   = pending_target(pending_next);
                    pending_next = PEND_NONE;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                pending_next = PEND_NONE;
            end
        endcase

        // Hazard preempts from any state and ignores same-cycle presses.
        if (hazard_level && (state != ST_HAZARD)) begin
            state_next   = ST_HAZARD;
            pending_next = pending;
        end
    end

    // Output decode for the next state; DRAIN keeps the outgoing enable.
    always_comb begin
        en_next = '0;
        unique case (state_next)
            ST_LEFT:   en_next.left   = 1'b1;
            ST_RIGHT:  en_next.right  = 1'b1;
            ST_HAZARD: en_next.hazard = 1'b1;
            ST_DRAIN: begin
                en_next.left  = en.left;
                en_next.right = en.right;
            end
            default:   en_next = '0;
        endcase
    end

    assign left_en    = en.left;
    assign right_en   = en.right;
    assign hazard_en  = en.hazard;
    assign state_code = state;

endmodule
